// File: rtl/branchpredictor.sv
// Branch resolution and prediction unit for the LEGv8 datapath: resolves B/CB/B.cond in
// execute, predicts fetch-stage branches from a PC-indexed table of saturating counters.

`ifndef OPCODESIZE
`define OPCODESIZE 11
`endif
`ifndef REGADDRSIZE
`define REGADDRSIZE 5
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif
`ifndef B_MASK
`define B_MASK 11'b000101?????
`endif
`ifndef CB_MASK
`define CB_MASK 11'b1011010????
`endif
`ifndef BFLAG_MASK
`define BFLAG_MASK 11'b01010100???
`endif

module branchpredictor #(
  parameter int ENTRIES   = 64,
  parameter int CTRWIDTH  = 2,
  parameter int PCWIDTH   = 64,
  parameter int STATWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    ready,
  input  logic                    pred_req,
  input  logic [PCWIDTH-1:0]      pred_pc,
  output logic                    pred_valid,
  output logic                    pred_taken,
  input  logic                    res_valid,
  input  logic [PCWIDTH-1:0]      res_pc,
  input  logic [`OPCODESIZE-1:0]  res_opcode,
  input  logic [`REGADDRSIZE-1:0] res_rd,
  input  logic [`FLAGSIZE-1:0]    res_flags,
  input  logic                    res_zero,
  input  logic                    res_predicted,
  output logic                    res_out_valid,
  output logic                    res_branch,
  output logic                    res_mispredict,
  input  logic                    stat_clear,
  output logic [STATWIDTH-1:0]    stat_branches,
  output logic [STATWIDTH-1:0]    stat_mispredicts,
  output logic                    dbg_state
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [CTRWIDTH-1:0] INITV   = CTRWIDTH'((1 << (CTRWIDTH - 1)) - 1);
  localparam logic [CTRWIDTH-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state, state_next;
  logic [IDXW-1:0]     ptr;
  logic [CTRWIDTH-1:0] table_q [ENTRIES];

  logic [IDXW-1:0]     pred_idx, res_idx, wr_idx;
  logic                pred_acc, res_acc;
  logic                n, z, v, c;
  logic                cond_true, is_br, taken, wr_en;
  logic [CTRWIDTH-1:0] cur_ctr, wr_data;

  logic unused_bits;
  assign unused_bits = ^{pred_pc[PCWIDTH-1:IDXW+2], pred_pc[1:0],
                         res_pc[PCWIDTH-1:IDXW+2], res_pc[1:0], res_rd[`REGADDRSIZE-1:4]};

  assign ready     = (state == S_RUN);
  assign dbg_state = state;
  assign pred_idx  = pred_pc[IDXW+1:2];
  assign res_idx   = res_pc[IDXW+1:2];
  assign pred_acc  = pred_req & ready;
  assign res_acc   = res_valid & ready;
  assign {n, z, v, c} = res_flags;

  always_comb begin
    state_next = state;
    if (state == S_INIT && ptr == IDXW'(ENTRIES - 1)) state_next = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == S_INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (res_rd[3:0])
      4'h0: cond_true = z;
      4'h1: cond_true = ~z;
      4'h2: cond_true = c;
      4'h3: cond_true = ~c;
      4'h4: cond_true = n;
      4'h5: cond_true = ~n;
      4'h6: cond_true = v;
      4'h7: cond_true = ~v;
      4'h8: cond_true = ~z & c;
      4'h9: cond_true = ~(~z & c);
      4'hA: cond_true = (n == v);
      4'hB: cond_true = (n != v);
      4'hC: cond_true = ~z & (n == v);
      4'hD: cond_true = ~(~z & (n == v));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    is_br = 1'b0;
    taken = 1'b0;
    casez (res_opcode)
      `B_MASK:     begin is_br = 1'b1; taken = 1'b1; end
      `CB_MASK:    begin is_br = 1'b1; taken = res_opcode[3] ? ~res_zero : res_zero; end
      `BFLAG_MASK: begin is_br = 1'b1; taken = cond_true; end
      default:     begin is_br = 1'b0; taken = 1'b0; end
    endcase
  end

  // One table write port: the init sweep owns it in INIT, training owns it in RUN.
  always_comb begin
    cur_ctr = table_q[res_idx];
    wr_en   = 1'b0;
    wr_idx  = res_idx;
    wr_data = cur_ctr;
    if (state == S_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = ptr;
      wr_data = INITV;
    end else if (res_acc && is_br) begin
      wr_en = 1'b1;
      if (taken) wr_data = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + 1'b1;
      else       wr_data = (cur_ctr == '0) ? cur_ctr : cur_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) table_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      res_out_valid    <= 1'b0;
      res_branch       <= 1'b0;
      res_mispredict   <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      pred_valid     <= pred_acc;
      pred_taken     <= pred_acc & table_q[pred_idx][CTRWIDTH-1];
      res_out_valid  <= res_acc;
      res_branch     <= res_acc & is_br & taken;
      res_mispredict <= res_acc & is_br & (taken != res_predicted);
      if (stat_clear) begin
        stat_branches    <= '0;
        stat_mispredicts <= '0;
      end else if (res_acc && is_br) begin
        if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
        if (taken != res_predicted && stat_mispredicts != '1)
          stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branchpredictor.sv
// Directed bench for branchpredictor: expected results are queued when stimulus is driven
// and compared one cycle later when the unit registers its outputs.

module tb_branchpredictor;

  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_BC   = 11'b01010100000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ready;
  logic        pred_req = 1'b0;
  logic [63:0] pred_pc = '0;
  logic        pred_valid, pred_taken;
  logic        res_valid = 1'b0;
  logic [63:0] res_pc = '0;
  logic [10:0] res_opcode = '0;
  logic [4:0]  res_rd = '0;
  logic [3:0]  res_flags = '0;
  logic        res_zero = 1'b0;
  logic        res_predicted = 1'b0;
  logic        res_out_valid, res_branch, res_mispredict;
  logic        stat_clear = 1'b0;
  logic [3:0]  stat_branches, stat_mispredicts;
  logic        dbg_state;

  int total = 0;
  int bad = 0;

  logic [0:0] pred_exp_q[$];
  logic [1:0] res_exp_q[$];
  logic [1:0] model [64];
  int         exp_br = 0;
  int         exp_mis = 0;
  logic       inc_br = 1'b0;
  logic       inc_mis = 1'b0;
  logic       clr_pend = 1'b0;

  branchpredictor #(.ENTRIES(64), .CTRWIDTH(2), .PCWIDTH(64), .STATWIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .ready(ready),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode), .res_rd(res_rd),
    .res_flags(res_flags), .res_zero(res_zero), .res_predicted(res_predicted),
    .res_out_valid(res_out_valid), .res_branch(res_branch), .res_mispredict(res_mispredict),
    .stat_clear(stat_clear), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fv, fc;
    {fn, fz, fv, fc} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive_pred(input logic [63:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    pred_exp_q.push_back(model[pc[7:2]][1]);
  endtask

  task automatic drive_res(input logic [10:0] op, input logic [3:0] cc, input logic [3:0] flags,
                           input logic zero, input logic predicted, input logic [63:0] pc);
    logic isbr, tk;
    res_valid = 1'b1; res_opcode = op; res_rd = {1'b0, cc}; res_flags = flags;
    res_zero = zero; res_predicted = predicted; res_pc = pc;
    isbr = 1'b1;
    if (op[10:5] == 6'b000101)       tk = 1'b1;
    else if (op[10:4] == 7'b1011010) tk = op[3] ? !zero : zero;
    else if (op[10:3] == 8'b01010100) tk = cond_ref(cc, flags);
    else begin isbr = 1'b0; tk = 1'b0; end
    res_exp_q.push_back({isbr & tk, isbr & (tk != predicted)});
    if (isbr) begin
      inc_br  = 1'b1;
      inc_mis = (tk != predicted);
      if (tk && model[pc[7:2]] != 2'd3)  model[pc[7:2]] = model[pc[7:2]] + 2'd1;
      if (!tk && model[pc[7:2]] != 2'd0) model[pc[7:2]] = model[pc[7:2]] - 2'd1;
    end
  endtask

  task automatic step(input string tag);
    logic [1:0] r;
    @(posedge clk);
    @(negedge clk);
    pred_req = 1'b0; res_valid = 1'b0; stat_clear = 1'b0;
    if (pred_exp_q.size() > 0) begin
      chk({tag, ".pred_valid"}, pred_valid, 1'b1);
      chk({tag, ".pred_taken"}, pred_taken, pred_exp_q.pop_front());
    end else chk({tag, ".pred_idle"}, pred_valid, 1'b0);
    if (res_exp_q.size() > 0) begin
      r = res_exp_q.pop_front();
      chk({tag, ".res_valid"}, res_out_valid, 1'b1);
      chk({tag, ".res_branch"}, res_branch, r[1]);
      chk({tag, ".res_mispredict"}, res_mispredict, r[0]);
    end else chk({tag, ".res_idle"}, res_out_valid, 1'b0);
    if (clr_pend) begin
      exp_br = 0; exp_mis = 0;
    end else begin
      if (inc_br && exp_br < 15)   exp_br++;
      if (inc_mis && exp_mis < 15) exp_mis++;
    end
    inc_br = 1'b0; inc_mis = 1'b0; clr_pend = 1'b0;
    chk({tag, ".stat_branches"}, stat_branches, exp_br[3:0]);
    chk({tag, ".stat_mispredicts"}, stat_mispredicts, exp_mis[3:0]);
  endtask

  task automatic do_reset(input int cycles);
    int n;
    resetn = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst.ready", ready, 1'b0);
    chk("rst.dbg_state", dbg_state, 1'b0);
    chk("rst.pred_valid", pred_valid, 1'b0);
    chk("rst.pred_taken", pred_taken, 1'b0);
    chk("rst.res_out_valid", res_out_valid, 1'b0);
    chk("rst.res_branch", res_branch, 1'b0);
    chk("rst.res_mispredict", res_mispredict, 1'b0);
    chk("rst.stat_branches", stat_branches, 4'd0);
    chk("rst.stat_mispredicts", stat_mispredicts, 4'd0);
    for (int i = 0; i < 64; i++) model[i] = 2'd1;
    exp_br = 0; exp_mis = 0;
    resetn = 1'b1;
    // Requests offered throughout INIT must be ignored.
    pred_req = 1'b1; pred_pc = 64'h40;
    res_valid = 1'b1; res_opcode = OP_B; res_predicted = 1'b0; res_pc = 64'h40;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      chk("init.pred_valid", pred_valid, 1'b0);
      chk("init.res_out_valid", res_out_valid, 1'b0);
    end
    pred_req = 1'b0; res_valid = 1'b0;
    chk("init.length", n, 64);
    chk("init.dbg_state", dbg_state, 1'b1);
    chk("init.stat_branches", stat_branches, 4'd0);
    chk("init.stat_mispredicts", stat_mispredicts, 4'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    // Fresh table predicts not-taken everywhere.
    drive_pred(64'h40); step("fresh40");
    drive_pred(64'h0);  step("fresh0");
    drive_pred(64'hFC); step("fresh_fc");

    // Training and saturation on pc 0x40.
    for (int i = 0; i < 3; i++) begin
      drive_res(OP_CBZ, 4'd0, 4'd0, 1'b1, 1'b0, 64'h40); step("cbz_taken");
    end
    drive_pred(64'h40); step("pred_sat");
    drive_res(OP_CBZ, 4'd0, 4'd0, 1'b0, 1'b1, 64'h40); step("cbz_nt1");
    drive_pred(64'h40); step("pred_ctr2");
    drive_res(OP_CBZ, 4'd0, 4'd0, 1'b0, 1'b1, 64'h40); step("cbz_nt2");
    drive_pred(64'h40); step("pred_ctr1");

    // CBNZ polarity.
    drive_res(OP_CBNZ, 4'd0, 4'd0, 1'b0, 1'b0, 64'h80); step("cbnz_taken");
    drive_res(OP_CBNZ, 4'd0, 4'd0, 1'b1, 1'b0, 64'h80); step("cbnz_nt");

    // Full condition x flags sweep.
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        drive_res(OP_BC, 4'(cc), 4'(f), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 64'h100 + 64'(4 * $urandom_range(0, 63)));
        step("bcond");
      end
    end

    // Non-branch opcode: no result, no stats.
    clr_pend = 1'b1; stat_clear = 1'b1; step("clear1");
    drive_res(OP_ADD, 4'hE, 4'hF, 1'b1, 1'b1, 64'h40); step("add");

    // Mispredicted unconditional branch.
    drive_res(OP_B, 4'd0, 4'd0, 1'b0, 1'b0, 64'h44); step("b_mispred");
    chk("b_mispred.br_count", stat_branches, 4'd1);
    chk("b_mispred.mis_count", stat_mispredicts, 4'd1);

    // Same-index predict and resolve: predict sees the pre-update counter.
    drive_pred(64'hC0);
    drive_res(OP_CBZ, 4'd0, 4'd0, 1'b1, 1'b0, 64'hC0); step("collide");
    drive_pred(64'hC0); step("after_collide");

    // Statistics saturation and clear priority.
    clr_pend = 1'b1; stat_clear = 1'b1; step("clear2");
    for (int i = 0; i < 16; i++) begin
      drive_res(OP_B, 4'd0, 4'd0, 1'b0, 1'b1, 64'h48); step("sat_br");
    end
    chk("sat.br_count", stat_branches, 4'd15);
    chk("sat.mis_count", stat_mispredicts, 4'd0);
    clr_pend = 1'b1; stat_clear = 1'b1;
    drive_res(OP_B, 4'd0, 4'd0, 1'b0, 1'b0, 64'h48); step("clear_vs_inc");
    chk("clear_vs_inc.br_count", stat_branches, 4'd0);

    // Reset mid-run wipes trained state.
    drive_res(OP_CBZ, 4'd0, 4'd0, 1'b1, 1'b1, 64'hC0); step("train_c0");
    drive_pred(64'hC0); step("pred_c0_trained");
    do_reset(1);
    drive_pred(64'hC0); step("pred_c0_after_reset");

    chk("pred_q_empty", pred_exp_q.size(), 0);
    chk("res_q_empty", res_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
